// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one instruction-memory request in flight,
// and presents fetched instructions to the IF/ID register while handling stalls and redirects.
module fetch_stage #(
    parameter int               ADDR_W   = 32,
    parameter int               INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirectPC,
    output logic               imemReq,
    output logic [ADDR_W-1:0]  imemAddr,
    input  logic               imemReady,
    input  logic               imemRespValid,
    input  logic [INSTR_W-1:0] imemRespData,
    output logic [ADDR_W-1:0]  PCOut,
    output logic [INSTR_W-1:0] instrOut,
    output logic               fetchValid,
    output logic               IFIDFlush
);

    typedef enum logic [1:0] {
        STATE_REQ,
        STATE_WAIT,
        STATE_HOLD,
        STATE_DISCARD
    } fetchState_t;

    fetchState_t        state;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instrBuf;
    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  pcPlus4;
    logic               unusedLowBits;

    // Redirect targets are always word aligned; the low bits are dropped here.
    assign target        = {redirectPC[ADDR_W-1:2], 2'b00};
    assign unusedLowBits = ^redirectPC[1:0];
    assign pcPlus4       = pc + ADDR_W'(4);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= STATE_REQ;
            pc       <= RESET_PC;
            instrBuf <= '0;
        end else begin
            case (state)
                STATE_REQ: begin
                    if (redirect) begin
                        pc <= target;
                    end else if (imemReady) begin
                        state <= STATE_WAIT;
                    end
                end
                STATE_WAIT: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= imemRespValid ? STATE_REQ : STATE_DISCARD;
                    end else if (imemRespValid) begin
                        if (stall) begin
                            instrBuf <= imemRespData;
                            state    <= STATE_HOLD;
                        end else begin
                            pc    <= pcPlus4;
                            state <= STATE_REQ;
                        end
                    end
                end
                STATE_HOLD: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= STATE_REQ;
                    end else if (!stall) begin
                        pc    <= pcPlus4;
                        state <= STATE_REQ;
                    end
                end
                STATE_DISCARD: begin
                    // The stale response is still owed by memory; swallow it before re-requesting.
                    if (redirect) begin
                        pc <= target;
                    end
                    if (imemRespValid) begin
                        state <= STATE_REQ;
                    end
                end
                default: state <= STATE_REQ;
            endcase
        end
    end

    // A response is shown to decode in its arrival cycle; a stalled one is replayed from the buffer.
    always_comb begin
        fetchValid = 1'b0;
        instrOut   = '0;
        case (state)
            STATE_WAIT: begin
                if (imemRespValid && !redirect) begin
                    fetchValid = 1'b1;
                    instrOut   = imemRespData;
                end
            end
            STATE_HOLD: begin
                fetchValid = 1'b1;
                instrOut   = instrBuf;
            end
            default: begin
                fetchValid = 1'b0;
                instrOut   = '0;
            end
        endcase
    end

    assign imemReq   = (state == STATE_REQ) && !redirect && !reset;
    assign imemAddr  = pc;
    assign PCOut     = pc;
    assign IFIDFlush = !fetchValid || redirect;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the PC and issues single-outstanding requests to instruction memory over a ready/valid handshake.
- Absorbs memory latency, decode stalls and branch/jump redirects.
- Drives PC, instruction and the IF/ID flush into the IF/ID register. The IF/ID register has no enable, so stall is implemented here by holding outputs stable.

Parameters:
ADDR_W, 32, PC / instruction-memory address width
INSTR_W, 32, instruction width
RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
stall  in  1  decode cannot accept; hold presented instruction
redirect  in  1  taken branch/jump resolved downstream; valid for one cycle
redirectPC  in  ADDR_W  redirect target; bits [1:0] forced to 0 internally
imemReq  out  1  request valid to instruction memory
imemAddr  out  ADDR_W  request address (= PC)
imemReady  in  1  memory accepts request this cycle
imemRespValid  in  1  response data valid
imemRespData  in  INSTR_W  fetched instruction
PCOut  out  ADDR_W  PC of presented instruction, to IF/ID PCIn
instrOut  out  INSTR_W  presented instruction, to IF/ID instrIn
fetchValid  out  1  PCOut/instrOut carry a real instruction
IFIDFlush  out  1  flush to IF/ID register

Behaviour:
- Reset (async) values: state=REQ, PC=RESET_PC, instruction buffer=0, fetchValid=0, IFIDFlush=1, PCOut=RESET_PC, instrOut=0, imemReq=0 while reset is high.
- State REQ:
  - imemReq = !redirect; imemAddr = PC.
  - redirect: PC <= {redirectPC[ADDR_W-1:2],2'b00}; stay REQ; no request issued.
  - Else imemReady: go to WAIT. Else stay REQ.
  - imemRespValid is ignored in REQ.
- State WAIT (request outstanding, imemReq=0):
  - redirect && !imemRespValid: PC <= target; go to DISCARD.
  - redirect && imemRespValid: drop response; PC <= target; go to REQ.
  - imemRespValid && !redirect && !stall: present response combinationally (fetchValid=1, instrOut=imemRespData, PCOut=PC); PC <= PC+4; go to REQ.
  - imemRespValid && !redirect && stall: present response the same way; latch it into the buffer; go to HOLD; PC unchanged.
  - No response: stay WAIT.
- State HOLD (buffered instruction, imemReq=0):
  - fetchValid=1, instrOut=buffer, PCOut=PC.
  - redirect: drop buffer; PC <= target; go to REQ.
  - Else !stall: PC <= PC+4; go to REQ.
  - Else stay HOLD with outputs unchanged.
- State DISCARD (stale request in flight, imemReq=0):
  - imemRespValid: drop data; go to REQ.
  - redirect while in DISCARD: PC <= newest target; stay DISCARD.
- Consumption: an instruction is consumed in the cycle fetchValid && !stall && !redirect.
- When fetchValid=0: PCOut=PC, instrOut=0.
- IFIDFlush = !fetchValid || redirect. Redirect always wins over stall and delivery in the same cycle.
- PC+4 wraps modulo 2^ADDR_W (all-ones-aligned PC -> 0). No misalignment exception.
- At most one outstanding request.
- Throughput: one instruction per 2 cycles at 1-cycle memory latency.
- Reset mid-WAIT/DISCARD returns to REQ. Any response arriving afterwards while in REQ is ignored.

Test Plan:
- Reset release, imemReady=1, response 1 cycle after accept, data 0x00500093 then 0x00100113 -> imemAddr 0x0, 0x4; fetchValid pulses with PCOut 0x0/0x4; IFIDFlush=0 only in those cycles.
- Response arrives with stall=1 for 3 cycles -> HOLD; instrOut/PCOut constant for 3 cycles, no new imemReq; on stall=0 next imemAddr = PC+4.
- redirect to 0x103 while WAIT, response arrives 2 cycles later -> stale data never presented (fetchValid=0); next imemAddr = 0x100.
- redirect coincident with imemRespValid and stall=1 -> IFIDFlush=1 that cycle; no HOLD; next imemAddr = target.
- PC = 2^ADDR_W-4, instruction consumed -> next imemAddr = 0.
- Assert reset during WAIT, then release with a late response -> response ignored; imemReq asserts with imemAddr = RESET_PC.
